// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: runs an E/F up/down counter for a commanded number of cycles and checks the final count
module updown_seq_ctrl #(
  parameter int STEP_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  input  logic              clr_err,
  input  logic [CNT_W-1:0]  y_in,
  output logic              cnt_e,
  output logic              cnt_f,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left,
  output logic              done,
  output logic              aborted,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;
  state_t state, state_n;
  logic dir, go;
  logic [CNT_W-1:0] exp_cnt;
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    go = cmd_valid & cmd_ready;
    state_n = state == IDLE ? (go ? (cmd_steps == '0 ? CHECK : RUN) : IDLE)
            : state == RUN  ? (abort ? IDLE : steps_left == STEP_W'(1) ? CHECK : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dir        <= 1'b0;
      steps_left <= '0;
      exp_cnt    <= '0;
      err        <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      aborted <= state == RUN && abort;
      err     <= (state == CHECK && y_in != exp_cnt) || (err && !clr_err);
      if (go) begin
        dir        <= cmd_dir;
        steps_left <= cmd_steps;
        exp_cnt    <= cmd_dir ? y_in + CNT_W'(cmd_steps) : y_in - CNT_W'(cmd_steps);
      end else if (state == RUN) begin
        steps_left <= abort ? '0 : steps_left - STEP_W'(1);
      end
    end
  end
  always_comb begin
    cmd_ready = rstn && state == IDLE;
    cnt_e     = state == RUN;
    cnt_f     = dir;
    busy      = state != IDLE;
    done      = state == CHECK;
  end
endmodule
